conv_operand_feeder: RTL and testbench
======================================

// Module: conv_operand_feeder
// PURPOSE
// - Transmit side of the a/b operand handshake used by the conv controller FSM.
// - Walks the loop nest and reads activations (a) and kernel weights (b) from two synchronous memories.
// - Loop order, outer to inner: x, y, ch_in, ch_out, k_v, k_h.
// - Presents one {a,b} operand pair per transfer at up to 1 pair/cycle, with backpressure.
// - Sits between the operand memories and the controller/datapath.
// PARAMETERS
// FEATURE_MAP_WIDTH   default 1024  input feature map width (pixels)
// FEATURE_MAP_HEIGHT  default 1024  input feature map height (pixels)
// INPUT_NB_CHANNELS   default 64    ch_in loop bound
// OUTPUT_NB_CHANNELS  default 64    ch_out loop bound
// KERNEL_SIZE         default 3     kernel edge (odd)
// DATA_WIDTH          default 16    width of a_data/b_data and memory read data
// ADDR_WIDTH          default 32    memory address width
// PORTS
// clk        in   1           clock, all state on rising edge
// arst_n_in  in   1           asynchronous reset, active low
// start      in   1           begin one full pass; ignored while running
// running    out  1           high from cycle after accepted start until done pulse
// done       out  1           1-cycle pulse after the last pair is transferred
// fm_re      out  1           activation memory read enable
// fm_addr    out  ADDR_WIDTH  activation read address
// fm_rdata   in   DATA_WIDTH  activation data, valid 1 cycle after fm_re
// k_re       out  1           kernel memory read enable
// k_addr     out  ADDR_WIDTH  kernel read address
// k_rdata    in   DATA_WIDTH  kernel data, valid 1 cycle after k_re
// a_valid    out  1           a_data valid
// a_ready    in   1           consumer accepts a
// a_data     out  DATA_WIDTH  activation operand
// b_valid    out  1           b_data valid
// b_ready    in   1           consumer accepts b
// b_data     out  DATA_WIDTH  weight operand
// BEHAVIOUR
// - Reset values: running, done, fm_re, k_re, a_valid, b_valid = 0; addresses and data = 0; all counters 0; state IDLE.
// - Pairing: a_valid == b_valid always. A pair transfers on a cycle where a_valid && a_ready && b_ready.
//   - a_ready without b_ready (or the reverse) transfers nothing.
// - Stability: once valid rises, valid, a_data and b_data hold until the transfer.
// - FSM states and transitions:
//   - IDLE: start=1 -> STREAM; all counters cleared.
//   - STREAM: issues one read pair per cycle while (buffered + in-flight) < 2. Buffer is a 2-entry FIFO.
//     After issuing the last tuple -> DRAIN.
//   - DRAIN: no reads; buffer empties -> IDLE with done=1 for one cycle.
// - Latency and throughput:
//   - Memory latency is 1 cycle, so the first a_valid appears 2 cycles after start.
//   - Throughput is 1 pair/cycle with readies held high.
// - Counter update: k_h increments each issue and wraps at KERNEL_SIZE-1. Each outer counter increments only when all inner counters wrap.
// - Input coordinates: xi = x + k_h - OFF, yi = y + k_v - OFF. OFF is set in CONFIGURATION.
// - fm_addr = (yi*FEATURE_MAP_WIDTH + xi)*INPUT_NB_CHANNELS + ch_in.
// - k_addr = ((ch_out*INPUT_NB_CHANNELS + ch_in)*KERNEL_SIZE + k_v)*KERNEL_SIZE + k_h.
// - Arithmetic: coordinate math is signed 32 bit; addresses are truncated to ADDR_WIDTH.
// - Out-of-range (xi or yi < 0, or >= map dimension): fm_re=0 for that tuple and the buffered a_data=0. k_re is still issued.
// - Simultaneous push and pop on a full buffer is allowed; occupancy stays 2.
// - Reset mid-operation: buffer is flushed, valid drops immediately, the returning read is discarded, state -> IDLE.
// - start during STREAM/DRAIN: ignored, no counter change.
// - start in the same cycle as done: accepted, a new pass begins.
// CONFIGURATION
// - Macro CONV_OPERAND_FEEDER_PAD_EN.
// - Defined (same-size convolution):
//   - OFF = KERNEL_SIZE/2; x loops 0..FEATURE_MAP_WIDTH-1 and y loops 0..FEATURE_MAP_HEIGHT-1.
//   - Border taps are zero-padded as described in BEHAVIOUR.
// - Undefined (valid convolution):
//   - OFF = 0; x loops 0..FEATURE_MAP_WIDTH-KERNEL_SIZE and y loops 0..FEATURE_MAP_HEIGHT-KERNEL_SIZE.
//   - Taps are never out of range and the pad logic is absent.
// TESTING (W=H=4, Cin=Cout=2, K=3, memories hold data = address[15:0])
// - Reset: arst_n_in=0 -> all outputs 0. Release with no start -> running stays 0.
// - PAD_EN, readies held high, start:
//   - Exactly 576 pairs, one per cycle.
//   - Pair 0: a_data=0 (padded), fm_re=0, b_data=0.
//   - Pair 4 (k_v=1,k_h=1): a_data=0, b_data=4.
//   - done after the last pair.
// - No PAD_EN, same stimulus:
//   - Exactly 144 pairs.
//   - Pair 0: a_data=0, b_data=0.
//   - Pair 1: a_data=2 (xi=1,ch_in=0), b_data=1.
// - Random backpressure (each ready low 50%, independently):
//   - Sequence is identical to the no-stall run.
//   - Data is stable while valid && !ready; no loss or duplication.
// - start pulsed at pair 50: pair count and order are unchanged.
// - arst_n_in low at pair 100: valid=0 immediately. A new start restarts from pair 0.

Source files
------------

// File: rtl/conv_operand_feeder.sv
// conv_operand_feeder
// Transmit side of the a/b operand handshake for the conv controller. The block walks the
// loop nest x, y, ch_in, ch_out, k_v, k_h (outer to inner). For every tuple it issues one
// activation read and one kernel read, and it presents the returned pair as {a_data, b_data}
// under a valid/ready handshake. At most one pair is transferred per cycle.
//
// Configuration macro: CONV_OPERAND_FEEDER_PAD_EN
//   defined   -> same-size convolution. Border taps are zero padded and no fm read is issued.
//   undefined -> valid convolution. Taps never fall outside the map, so no pad logic is built.
//
// Ports
//   clk, arst_n_in        clock (rising edge), asynchronous active-low reset
//   start                 begin one full pass; ignored while a pass is in progress
//   running, done         pass in progress; 1-cycle pulse after the last pair is transferred
//   fm_re/fm_addr/fm_rdata   activation memory port (read data valid 1 cycle after fm_re)
//   k_re/k_addr/k_rdata      kernel memory port (read data valid 1 cycle after k_re)
//   a_valid/a_ready/a_data   activation operand handshake
//   b_valid/b_ready/b_data   weight operand handshake (b_valid always equals a_valid)
module conv_operand_feeder #(
  parameter int unsigned FEATURE_MAP_WIDTH  = 1024,
  parameter int unsigned FEATURE_MAP_HEIGHT = 1024,
  parameter int unsigned INPUT_NB_CHANNELS  = 64,
  parameter int unsigned OUTPUT_NB_CHANNELS = 64,
  parameter int unsigned KERNEL_SIZE        = 3,
  parameter int unsigned DATA_WIDTH         = 16,
  parameter int unsigned ADDR_WIDTH         = 32
) (
  input  logic                  clk,
  input  logic                  arst_n_in,
  input  logic                  start,
  output logic                  running,
  output logic                  done,
  output logic                  fm_re,
  output logic [ADDR_WIDTH-1:0] fm_addr,
  input  logic [DATA_WIDTH-1:0] fm_rdata,
  output logic                  k_re,
  output logic [ADDR_WIDTH-1:0] k_addr,
  input  logic [DATA_WIDTH-1:0] k_rdata,
  output logic                  a_valid,
  input  logic                  a_ready,
  output logic [DATA_WIDTH-1:0] a_data,
  output logic                  b_valid,
  input  logic                  b_ready,
  output logic [DATA_WIDTH-1:0] b_data
);

`ifdef CONV_OPERAND_FEEDER_PAD_EN
  localparam int          OFF    = int'(KERNEL_SIZE / 2);
  localparam logic [31:0] X_LAST = FEATURE_MAP_WIDTH - 1;
  localparam logic [31:0] Y_LAST = FEATURE_MAP_HEIGHT - 1;
`else
  localparam int          OFF    = 0;
  localparam logic [31:0] X_LAST = FEATURE_MAP_WIDTH - KERNEL_SIZE;
  localparam logic [31:0] Y_LAST = FEATURE_MAP_HEIGHT - KERNEL_SIZE;
`endif
  localparam logic [31:0] CI_LAST = INPUT_NB_CHANNELS - 1;
  localparam logic [31:0] CO_LAST = OUTPUT_NB_CHANNELS - 1;
  localparam logic [31:0] K_LAST  = KERNEL_SIZE - 1;
  localparam int          W_I     = int'(FEATURE_MAP_WIDTH);
  localparam int          H_I     = int'(FEATURE_MAP_HEIGHT);
  localparam int          CIN_I   = int'(INPUT_NB_CHANNELS);
  localparam int          K_I     = int'(KERNEL_SIZE);

  typedef enum logic [1:0] {StIdle, StStream, StDrain} state_e;

  state_e      r_state;
  logic        r_running;
  logic        r_done;
  logic [31:0] r_x, r_y, r_ci, r_co, r_kv, r_kh;

  // Two-entry operand buffer plus the one read that may be in flight from memory.
  logic [DATA_WIDTH-1:0] r_fa [2];
  logic [DATA_WIDTH-1:0] r_fb [2];
  logic                  r_rd;
  logic                  r_wr;
  logic [1:0]            r_cnt;
  logic                  r_inflight;
`ifdef CONV_OPERAND_FEEDER_PAD_EN
  logic                  r_fly_pad;
`endif

  logic                  w_inc_kv, w_inc_co, w_inc_ci, w_inc_y, w_inc_x, w_last;
  logic signed [31:0]    w_xi, w_yi, w_fm_lin, w_k_lin;
  logic                  w_in_range;
  logic [1:0]            w_occ;
  logic                  w_issue;
  logic [DATA_WIDTH-1:0] w_arr_a;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_fifo_pop;
  logic [1:0]            w_cnt_nxt;

  // Each outer counter advances only when every inner counter wraps.
  assign w_inc_kv = (r_kh == K_LAST);
  assign w_inc_co = w_inc_kv && (r_kv == K_LAST);
  assign w_inc_ci = w_inc_co && (r_co == CO_LAST);
  assign w_inc_y  = w_inc_ci && (r_ci == CI_LAST);
  assign w_inc_x  = w_inc_y && (r_y == Y_LAST);
  assign w_last   = w_inc_x && (r_x == X_LAST);

  always_comb begin
    w_xi     = $signed(r_x) + $signed(r_kh) - OFF;
    w_yi     = $signed(r_y) + $signed(r_kv) - OFF;
    w_fm_lin = (w_yi * W_I + w_xi) * CIN_I + $signed(r_ci);
    w_k_lin  = (($signed(r_co) * CIN_I + $signed(r_ci)) * K_I + $signed(r_kv)) * K_I
               + $signed(r_kh);
`ifdef CONV_OPERAND_FEEDER_PAD_EN
    w_in_range = !((w_xi < 0) || (w_xi >= W_I) || (w_yi < 0) || (w_yi >= H_I));
`else
    w_in_range = 1'b1;
`endif
  end

  // Never let buffered + in-flight exceed the buffer depth, so a returning read always fits.
  assign w_occ   = r_cnt + {1'b0, r_inflight};
  assign w_issue = (r_state == StStream) && (w_occ < 2'd2);

  assign fm_re   = w_issue && w_in_range;
  assign fm_addr = fm_re ? ADDR_WIDTH'(w_fm_lin) : '0;
  assign k_re    = w_issue;
  assign k_addr  = w_issue ? ADDR_WIDTH'(w_k_lin) : '0;

`ifdef CONV_OPERAND_FEEDER_PAD_EN
  assign w_arr_a = r_fly_pad ? '0 : fm_rdata;
`else
  assign w_arr_a = fm_rdata;
`endif

  // With an empty buffer the returning read is presented directly; if it is not taken it
  // is captured into the buffer, so the visible value does not change.
  assign w_empty = (r_cnt == 2'd0);
  assign a_valid = !w_empty || r_inflight;
  assign b_valid = a_valid;
  assign a_data  = !w_empty ? r_fa[r_rd] : (r_inflight ? w_arr_a : '0);
  assign b_data  = !w_empty ? r_fb[r_rd] : (r_inflight ? k_rdata : '0);

  assign w_pop      = a_valid && a_ready && b_ready;
  assign w_push     = r_inflight && !(w_empty && w_pop);
  assign w_fifo_pop = w_pop && !w_empty;
  assign w_cnt_nxt  = r_cnt + {1'b0, w_push} - {1'b0, w_fifo_pop};

  assign running = r_running;
  assign done    = r_done;

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      r_cnt      <= 2'd0;
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
      r_inflight <= 1'b0;
`ifdef CONV_OPERAND_FEEDER_PAD_EN
      r_fly_pad  <= 1'b0;
`endif
      for (int i = 0; i < 2; i++) begin
        r_fa[i] <= '0;
        r_fb[i] <= '0;
      end
    end else begin
      r_inflight <= w_issue;
`ifdef CONV_OPERAND_FEEDER_PAD_EN
      r_fly_pad  <= w_issue && !w_in_range;
`endif
      if (w_push) begin
        r_fa[r_wr] <= w_arr_a;
        r_fb[r_wr] <= k_rdata;
        r_wr       <= ~r_wr;
      end
      if (w_fifo_pop) r_rd <= ~r_rd;
      r_cnt <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      r_state   <= StIdle;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
      r_ci      <= '0;
      r_co      <= '0;
      r_kv      <= '0;
      r_kh      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (start) begin
            r_state   <= StStream;
            r_running <= 1'b1;
            r_x       <= '0;
            r_y       <= '0;
            r_ci      <= '0;
            r_co      <= '0;
            r_kv      <= '0;
            r_kh      <= '0;
          end
        end
        StStream: begin
          if (w_issue) begin
            r_kh <= w_inc_kv ? '0 : r_kh + 32'd1;
            if (w_inc_kv) r_kv <= w_inc_co ? '0 : r_kv + 32'd1;
            if (w_inc_co) r_co <= w_inc_ci ? '0 : r_co + 32'd1;
            if (w_inc_ci) r_ci <= w_inc_y ? '0 : r_ci + 32'd1;
            if (w_inc_y)  r_y  <= w_inc_x ? '0 : r_y + 32'd1;
            if (w_inc_x)  r_x  <= w_last ? '0 : r_x + 32'd1;
            if (w_last) r_state <= StDrain;
          end
        end
        StDrain: begin
          // Leave once the final entry is transferred this cycle; done follows next cycle.
          if (w_cnt_nxt == 2'd0) begin
            r_state   <= StIdle;
            r_running <= 1'b0;
            r_done    <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_operand_feeder.sv
module tb_conv_operand_feeder;
  localparam int W = 4, H = 4, CI = 2, CO = 2, K = 3, DW = 16, AW = 32;
`ifdef CONV_OPERAND_FEEDER_PAD_EN
  localparam bit PAD = 1'b1;
  localparam int OFF = K / 2;
  localparam int XN = W, YN = H;
`else
  localparam bit PAD = 1'b0;
  localparam int OFF = 0;
  localparam int XN = W - K + 1, YN = H - K + 1;
`endif

  logic clk = 1'b0;
  logic arst_n_in, start, running, done;
  logic fm_re, k_re, a_valid, a_ready, b_valid, b_ready;
  logic [AW-1:0] fm_addr, k_addr;
  logic [DW-1:0] fm_rdata, k_rdata, a_data, b_data;

  int n_checks = 0;
  int n_errors = 0;

  conv_operand_feeder #(
    .FEATURE_MAP_WIDTH(W), .FEATURE_MAP_HEIGHT(H), .INPUT_NB_CHANNELS(CI),
    .OUTPUT_NB_CHANNELS(CO), .KERNEL_SIZE(K), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .arst_n_in(arst_n_in), .start(start), .running(running), .done(done),
    .fm_re(fm_re), .fm_addr(fm_addr), .fm_rdata(fm_rdata),
    .k_re(k_re), .k_addr(k_addr), .k_rdata(k_rdata),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data)
  );

  always #5 clk = ~clk;

  // Synchronous memories holding data = address[15:0]; garbage when not read.
  always @(posedge clk) begin
    fm_rdata <= fm_re ? fm_addr[15:0] : 16'hBEEF;
    k_rdata  <= k_re ? k_addr[15:0] : 16'hBEEF;
  end

  // Reference model: expected issue and transfer sequences, straight from the loop nest.
  logic [15:0] m_a[$], m_b[$];
  bit          m_fre[$];
  logic [31:0] m_faddr[$], m_kaddr[$];
  // Captured from the DUT during one pass.
  logic [15:0] c_a[$], c_b[$];
  bit          c_fre[$];
  logic [31:0] c_faddr[$], c_kaddr[$];

  typedef struct {
    int          idx;
    logic [15:0] a;
    logic [15:0] b;
    bit          fre;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic void build_model();
    int xi, yi, fa, ka;
    bit inr;
    for (int x = 0; x < XN; x++)
      for (int y = 0; y < YN; y++)
        for (int ci = 0; ci < CI; ci++)
          for (int co = 0; co < CO; co++)
            for (int kv = 0; kv < K; kv++)
              for (int kh = 0; kh < K; kh++) begin
                xi  = x + kh - OFF;
                yi  = y + kv - OFF;
                inr = (xi >= 0) && (xi < W) && (yi >= 0) && (yi < H);
                fa  = (yi * W + xi) * CI + ci;
                ka  = ((co * CI + ci) * K + kv) * K + kh;
                m_fre.push_back(inr);
                m_faddr.push_back(32'(fa));
                m_kaddr.push_back(32'(ka));
                m_a.push_back(inr ? 16'(fa) : 16'h0);
                m_b.push_back(16'(ka));
              end
  endfunction

  task automatic compare_pass(input string tag);
    int nbad = 0;
    int ibad = 0;
    chk({tag, "_pair_count"}, c_a.size(), m_a.size());
    for (int i = 0; i < c_a.size() && i < m_a.size(); i++)
      if (c_a[i] !== m_a[i] || c_b[i] !== m_b[i]) begin
        if (nbad == 0)
          $display("first differing pair %0d: a=%h/%h b=%h/%h", i, c_a[i], m_a[i], c_b[i], m_b[i]);
        nbad++;
      end
    chk({tag, "_pair_mismatches"}, nbad, 0);
    chk({tag, "_issue_count"}, c_kaddr.size(), m_kaddr.size());
    for (int i = 0; i < c_kaddr.size() && i < m_kaddr.size(); i++)
      if (c_fre[i] !== m_fre[i] || c_kaddr[i] !== m_kaddr[i] ||
          (m_fre[i] && c_faddr[i] !== m_faddr[i])) ibad++;
    chk({tag, "_issue_mismatches"}, ibad, 0);
  endtask

  // One pass. Entered and left at a negedge; start is raised at entry.
  task automatic run_pass(input string tag, input bit rand_bp, input int start_at,
                          input int rst_at);
    int cyc = 0, first_v = -1, first_x = -1, last_x = -1;
    int stab = 0, pair_err = 0;
    bit done_seen = 1'b0, pv = 1'b0, pxf = 1'b0, xf, did_start = 1'b0;
    logic [15:0] pa = '0, pb = '0;
    c_a.delete(); c_b.delete(); c_fre.delete(); c_faddr.delete(); c_kaddr.delete();
    start = 1'b1; a_ready = 1'b1; b_ready = 1'b1;
    for (int g = 0; g < 20000; g++) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == 1) begin
        chk({tag, "_running_after_start"}, running, 1);
        chk({tag, "_done_one_cycle"}, done, 0);
      end
      if (k_re) begin
        c_fre.push_back(fm_re); c_faddr.push_back(fm_addr); c_kaddr.push_back(k_addr);
      end
      if (a_valid !== b_valid) pair_err++;
      if (pv && !pxf && (!a_valid || a_data !== pa || b_data !== pb)) stab++;
      if (a_valid && first_v < 0) first_v = cyc;
      if (rst_at >= 0 && c_a.size() == rst_at) begin
        arst_n_in = 1'b0;
        #1;
        chk({tag, "_rst_a_valid"}, a_valid, 0);
        chk({tag, "_rst_b_valid"}, b_valid, 0);
        chk({tag, "_rst_running"}, running, 0);
        chk({tag, "_rst_k_re"}, k_re, 0);
        @(negedge clk);
        arst_n_in = 1'b1;
        return;
      end
      if (start_at >= 0 && c_a.size() == start_at && !did_start) begin
        start = 1'b1;
        did_start = 1'b1;
      end
      if (rand_bp) begin
        a_ready = 1'($urandom_range(0, 1));
        b_ready = 1'($urandom_range(0, 1));
      end
      xf = a_valid && a_ready && b_ready;
      if (xf) begin
        c_a.push_back(a_data); c_b.push_back(b_data);
        if (first_x < 0) first_x = cyc;
        last_x = cyc;
      end
      if (done) begin
        done_seen = 1'b1;
        chk({tag, "_running_low_at_done"}, running, 0);
        chk({tag, "_valid_low_at_done"}, a_valid, 0);
        break;
      end
      pv = a_valid; pxf = xf; pa = a_data; pb = b_data;
    end
    chk({tag, "_done_seen"}, done_seen, 1);
    chk({tag, "_done_after_last"}, cyc, last_x + 1);
    chk({tag, "_first_valid_latency"}, first_v, 2);
    if (!rand_bp) chk({tag, "_one_per_cycle"}, last_x - first_x + 1, c_a.size());
    chk({tag, "_stability_violations"}, stab, 0);
    chk({tag, "_pairing_violations"}, pair_err, 0);
    compare_pass(tag);
  endtask

  initial begin
    arst_n_in = 1'b0; start = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
    build_model();
    if (PAD) begin
      tbl[0] = '{0, 16'd0, 16'd0, 1'b0};    tbl[1] = '{4, 16'd0, 16'd4, 1'b1};
      tbl[2] = '{5, 16'd2, 16'd5, 1'b1};    tbl[3] = '{8, 16'd10, 16'd8, 1'b1};
      tbl[4] = '{9, 16'd0, 16'd18, 1'b0};   tbl[5] = '{18, 16'd0, 16'd9, 1'b0};
      tbl[6] = '{22, 16'd1, 16'd13, 1'b1};  tbl[7] = '{571, 16'd31, 16'd31, 1'b1};
      tbl[8] = '{575, 16'd0, 16'd35, 1'b0};
    end else begin
      tbl[0] = '{0, 16'd0, 16'd0, 1'b1};    tbl[1] = '{1, 16'd2, 16'd1, 1'b1};
      tbl[2] = '{4, 16'd10, 16'd4, 1'b1};   tbl[3] = '{8, 16'd20, 16'd8, 1'b1};
      tbl[4] = '{9, 16'd0, 16'd18, 1'b1};   tbl[5] = '{18, 16'd1, 16'd9, 1'b1};
      tbl[6] = '{36, 16'd8, 16'd0, 1'b1};   tbl[7] = '{72, 16'd2, 16'd0, 1'b1};
      tbl[8] = '{143, 16'd31, 16'd35, 1'b1};
    end

    #12;
    chk("reset_running", running, 0);   chk("reset_done", done, 0);
    chk("reset_fm_re", fm_re, 0);       chk("reset_k_re", k_re, 0);
    chk("reset_a_valid", a_valid, 0);   chk("reset_b_valid", b_valid, 0);
    chk("reset_fm_addr", fm_addr, 0);   chk("reset_k_addr", k_addr, 0);
    chk("reset_a_data", a_data, 0);     chk("reset_b_data", b_data, 0);
    @(negedge clk);
    arst_n_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_no_start_running", running, 0);
    chk("idle_no_start_k_re", k_re, 0);

    run_pass("plain", 1'b0, -1, -1);
    chk("expected_pairs", m_a.size(), PAD ? 576 : 144);
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].idx < c_a.size()) begin
        chk($sformatf("tbl%0d_a", tbl[i].idx), c_a[tbl[i].idx], tbl[i].a);
        chk($sformatf("tbl%0d_b", tbl[i].idx), c_b[tbl[i].idx], tbl[i].b);
        chk($sformatf("tbl%0d_fm_re", tbl[i].idx), c_fre[tbl[i].idx], tbl[i].fre);
      end else begin
        chk($sformatf("tbl%0d_present", tbl[i].idx), c_a.size(), tbl[i].idx + 1);
      end
    end

    // Back-to-back: start raised in the done cycle.
    chk("start_with_done", done, 1);
    run_pass("restart_on_done", 1'b0, -1, -1);
    run_pass("backpressure", 1'b1, -1, -1);
    run_pass("start_mid_pass", 1'b0, 50, -1);
    repeat (2) @(negedge clk);
    run_pass("reset_mid_pass", 1'b1, -1, 100);
    repeat (2) @(negedge clk);
    chk("after_reset_running", running, 0);
    run_pass("after_reset", 1'b0, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
